ex_mem_stage: RTL
=================

EX_MEM_STAGE -- requirements
Module: ex_mem_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width.
REQ-002 SHALL have port CLK  in  1  single clock, all state on rising edge.
REQ-003 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port stall_i  in  1  hold all state, e.g. during a memory wait.
REQ-005 SHALL have ports PC_I, IMM_I, Rs1_I, Rs2_I  in  XLEN each  ID/EX PC, immediate and register operands.
REQ-006 SHALL have ports Opcode_I[7], Funct3_I[3], ALU_Ctrl_I[3], Src_to_Reg_I[2], id_ex_rs1/rs2/rd[5]  in  ID/EX decode fields.
REQ-007 SHALL have ports Branch_I, Jump_I, Sub_I, ALU_Src1_Sel_I, ALU_Src2_Sel_I, Reg_Wr_En_I, MEM_Wr_En_I  in  1 each  ID/EX controls.
REQ-008 SHALL have ports mem_wb_data[XLEN], mem_wb_rd[5], reg_mem_wb_wr[1]  in  writeback forwarding source.
REQ-009 SHALL have ports redirect_o[1], redirect_pc_o[XLEN]  out  combinational taken-branch or jump request to fetch.
REQ-010 SHALL have ports ex_mem_alu_o, ex_mem_store_o, ex_mem_pc4_o  out  XLEN each  registered ALU result, store data and PC+4.
REQ-011 SHALL have ports ex_mem_rd_o[5], ex_mem_funct3_o[3], ex_mem_src_to_reg_o[2], ex_mem_reg_wr_o[1], ex_mem_mem_wr_o[1]  out  registered controls.

Function
REQ-012 SHALL select operand A as PC_I when ALU_Src1_Sel_I=1, else forwarded rs1; operand B as IMM_I when ALU_Src2_Sel_I=1, else forwarded rs2.
REQ-013 SHALL decode ALU_Ctrl_I as 000 ADD (SUB when Sub_I), 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL (SRA when Sub_I), 110 OR, 111 AND.
REQ-014 SHALL take the shift amount from operand B[4:0], wrap add/sub modulo 2^XLEN, and zero-extend SLT/SLTU results.
REQ-015 SHALL forward from its own EX/MEM register when ex_mem_reg_wr_o=1, ex_mem_rd_o!=0 and rd matches: pc4 if src_to_reg=10, else alu.
REQ-016 SHALL otherwise forward mem_wb_data when reg_mem_wb_wr=1, mem_wb_rd!=0 and rd matches; EX/MEM has priority; rd 0 is never forwarded.
REQ-017 SHALL evaluate the branch condition on the forwarded rs1/rs2 by Funct3_I: 000 EQ, 001 NE, 100 LT, 101 GE, 110 LTU, 111 GEU; other codes are not-taken.
REQ-018 SHALL assert redirect_o when the EX instruction is live and either Branch_I with the condition true or Jump_I.
REQ-019 SHALL drive redirect_pc_o as PC_I+IMM_I for a branch or JAL, and as (rs1+IMM_I) with bit0 cleared for JALR (Opcode_I=1100111).
REQ-020 SHALL, on a redirect at an unstalled edge, load a 2-bit squash counter with 2.
REQ-021 SHALL treat the EX instruction as dead while the counter is non-zero; a dead instruction produces no redirect and registers reg_wr=0 and mem_wr=0.
REQ-022 SHALL decrement the counter by one per unstalled edge, saturating at 0.
REQ-023 SHALL register all ex_mem_* outputs at each unstalled edge, one cycle of latency, with ex_mem_pc4_o=PC_I+4.
REQ-024 SHALL hold all registers and the counter while stall_i=1, and SHALL suppress redirect_o during a stall.

Reset
REQ-025 SHALL, while rst_n=0, asynchronously clear all ex_mem_* registers and the squash counter to 0.
REQ-026 SHALL, while rst_n=0, drive redirect_o=0 and redirect_pc_o=0.
REQ-027 SHALL, on reset asserted mid-squash, discard the pending squash and treat the first post-reset instruction as live.

Configuration
REQ-028 SHALL implement forwarding per REQ-015/016 only when macro EX_FWD_EN is defined; otherwise operands SHALL be Rs1_I and Rs2_I unmodified.

Verification
REQ-029 SHALL cover: ADD x3,x1,x2 then SUB x4,x3,x1 back-to-back with x1=5, x2=7 -> x4 result 7 with EX_FWD_EN defined, and the stale x3 value without it.
REQ-030 SHALL cover: BEQ with equal operands, PC=0x100, IMM=0x20 -> redirect_o=1, redirect_pc_o=0x120; the next two instructions register reg_wr=0.
REQ-031 SHALL cover: JALR with rs1=0x1003, IMM=4 -> redirect_pc_o=0x1006 and ex_mem_pc4_o=PC+4.
REQ-032 SHALL cover: stall_i=1 for 3 cycles during a squash -> the counter holds at its value and the outputs are unchanged.
REQ-033 SHALL cover: SRA with operand A=0x80000000 and shift 4 -> 0xF8000000; SLTU -1,1 -> 0.
REQ-034 SHALL cover: rst_n pulsed low mid-squash -> all outputs 0 and the next instruction is live.

Source files
------------

// File: rtl/ex_mem_stage.sv
// ex_mem_stage: RV32-style execute stage with an EX/MEM pipeline register and a branch/jump squash counter.
// Latency: ex_mem_* outputs are registered one cycle after their ID/EX inputs. redirect_o and redirect_pc_o are combinational.
// Backpressure: stall_i=1 freezes every register and the squash counter, and masks redirect_o.
// Ports: CLK/rst_n (async active-low); ID/EX operands and decode fields in; mem_wb_* is the writeback forwarding source;
//        redirect_o/redirect_pc_o go to fetch; ex_mem_* are the registered results.
// Optional feature: define EX_FWD_EN to enable operand forwarding from EX/MEM and MEM/WB.
//        With EX_FWD_EN undefined, Rs1_I and Rs2_I are used as they arrive.
module ex_mem_stage #(
   parameter int XLEN = 32
) (
   input  logic            CLK,
   input  logic            rst_n,
   input  logic            stall_i,
   input  logic [XLEN-1:0] PC_I,
   input  logic [XLEN-1:0] IMM_I,
   input  logic [XLEN-1:0] Rs1_I,
   input  logic [XLEN-1:0] Rs2_I,
   input  logic [6:0]      Opcode_I,
   input  logic [2:0]      Funct3_I,
   input  logic [2:0]      ALU_Ctrl_I,
   input  logic [1:0]      Src_to_Reg_I,
   input  logic [4:0]      id_ex_rs1,
   input  logic [4:0]      id_ex_rs2,
   input  logic [4:0]      id_ex_rd,
   input  logic            Branch_I,
   input  logic            Jump_I,
   input  logic            Sub_I,
   input  logic            ALU_Src1_Sel_I,
   input  logic            ALU_Src2_Sel_I,
   input  logic            Reg_Wr_En_I,
   input  logic            MEM_Wr_En_I,
   input  logic [XLEN-1:0] mem_wb_data,
   input  logic [4:0]      mem_wb_rd,
   input  logic            reg_mem_wb_wr,
   output logic            redirect_o,
   output logic [XLEN-1:0] redirect_pc_o,
   output logic [XLEN-1:0] ex_mem_alu_o,
   output logic [XLEN-1:0] ex_mem_store_o,
   output logic [XLEN-1:0] ex_mem_pc4_o,
   output logic [4:0]      ex_mem_rd_o,
   output logic [2:0]      ex_mem_funct3_o,
   output logic [1:0]      ex_mem_src_to_reg_o,
   output logic            ex_mem_reg_wr_o,
   output logic            ex_mem_mem_wr_o
);

   localparam logic [6:0] OPC_JALR = 7'b1100111;
   localparam logic [1:0] SRC_PC4  = 2'b10;

   logic [XLEN-1:0] ex_mem_alu_q, ex_mem_alu_d;
   logic [XLEN-1:0] ex_mem_store_q, ex_mem_store_d;
   logic [XLEN-1:0] ex_mem_pc4_q, ex_mem_pc4_d;
   logic [4:0]      ex_mem_rd_q, ex_mem_rd_d;
   logic [2:0]      ex_mem_funct3_q, ex_mem_funct3_d;
   logic [1:0]      ex_mem_src_to_reg_q, ex_mem_src_to_reg_d;
   logic            ex_mem_reg_wr_q, ex_mem_reg_wr_d;
   logic            ex_mem_mem_wr_q, ex_mem_mem_wr_d;
   logic [1:0]      squash_cnt_q, squash_cnt_d;

   logic [XLEN-1:0] rs1_fwd, rs2_fwd;
   logic [XLEN-1:0] op_a, op_b, alu_res, target;
   logic signed [XLEN-1:0] op_a_s;
   logic [4:0]      shamt;
   logic            live, br_eq, br_lt, br_ltu, br_cond, redirect_req;

   // Instructions in the two slots behind a taken redirect are wrong-path.
   assign live = (squash_cnt_q == 2'd0);

`ifdef EX_FWD_EN
   logic [XLEN-1:0] ex_mem_fwd_val;

   // A JAL/JALR in EX/MEM writes PC+4, not its ALU result.
   assign ex_mem_fwd_val = (ex_mem_src_to_reg_q == SRC_PC4) ? ex_mem_pc4_q : ex_mem_alu_q;

   // EX/MEM holds the younger value, so it takes priority over MEM/WB. x0 is never forwarded.
   always_comb begin
      rs1_fwd = Rs1_I;
      if (ex_mem_reg_wr_q && (ex_mem_rd_q != 5'd0) && (ex_mem_rd_q == id_ex_rs1))
         rs1_fwd = ex_mem_fwd_val;
      else if (reg_mem_wb_wr && (mem_wb_rd != 5'd0) && (mem_wb_rd == id_ex_rs1))
         rs1_fwd = mem_wb_data;
   end

   always_comb begin
      rs2_fwd = Rs2_I;
      if (ex_mem_reg_wr_q && (ex_mem_rd_q != 5'd0) && (ex_mem_rd_q == id_ex_rs2))
         rs2_fwd = ex_mem_fwd_val;
      else if (reg_mem_wb_wr && (mem_wb_rd != 5'd0) && (mem_wb_rd == id_ex_rs2))
         rs2_fwd = mem_wb_data;
   end
`else
   logic unused_fwd;

   assign rs1_fwd    = Rs1_I;
   assign rs2_fwd    = Rs2_I;
   assign unused_fwd = ^{mem_wb_data, mem_wb_rd, reg_mem_wb_wr, id_ex_rs1, id_ex_rs2};
`endif

   assign op_a   = ALU_Src1_Sel_I ? PC_I  : rs1_fwd;
   assign op_b   = ALU_Src2_Sel_I ? IMM_I : rs2_fwd;
   assign op_a_s = op_a;
   assign shamt  = op_b[4:0];

   always_comb begin
      alu_res = '0;
      case (ALU_Ctrl_I)
         3'b000: alu_res = Sub_I ? (op_a - op_b) : (op_a + op_b);
         3'b001: alu_res = op_a << shamt;
         3'b010: alu_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
         3'b011: alu_res = {{(XLEN-1){1'b0}}, (op_a < op_b)};
         3'b100: alu_res = op_a ^ op_b;
         3'b101: begin
            // Separate branches keep SRA signed; a ?: would force both arms unsigned.
            if (Sub_I) alu_res = op_a_s >>> shamt;
            else       alu_res = op_a >> shamt;
         end
         3'b110: alu_res = op_a | op_b;
         default: alu_res = op_a & op_b;
      endcase
   end

   assign br_eq  = (rs1_fwd == rs2_fwd);
   assign br_lt  = ($signed(rs1_fwd) < $signed(rs2_fwd));
   assign br_ltu = (rs1_fwd < rs2_fwd);

   always_comb begin
      br_cond = 1'b0;
      case (Funct3_I)
         3'b000: br_cond = br_eq;
         3'b001: br_cond = ~br_eq;
         3'b100: br_cond = br_lt;
         3'b101: br_cond = ~br_lt;
         3'b110: br_cond = br_ltu;
         3'b111: br_cond = ~br_ltu;
         default: br_cond = 1'b0;
      endcase
   end

   assign redirect_req = live & ((Branch_I & br_cond) | Jump_I);

   // JALR clears bit 0 of its target. Branches and JAL are PC-relative.
   assign target = (Opcode_I == OPC_JALR) ? ((rs1_fwd + IMM_I) & {{(XLEN-1){1'b1}}, 1'b0})
                                          : (PC_I + IMM_I);

   assign redirect_o    = rst_n & ~stall_i & redirect_req;
   assign redirect_pc_o = rst_n ? target : '0;

   always_comb begin
      squash_cnt_d = squash_cnt_q;
      if (!stall_i) begin
         if (redirect_o)                 squash_cnt_d = 2'd2;
         else if (squash_cnt_q != 2'd0)  squash_cnt_d = squash_cnt_q - 2'd1;
      end
   end

   always_comb begin
      ex_mem_alu_d        = ex_mem_alu_q;
      ex_mem_store_d      = ex_mem_store_q;
      ex_mem_pc4_d        = ex_mem_pc4_q;
      ex_mem_rd_d         = ex_mem_rd_q;
      ex_mem_funct3_d     = ex_mem_funct3_q;
      ex_mem_src_to_reg_d = ex_mem_src_to_reg_q;
      ex_mem_reg_wr_d     = ex_mem_reg_wr_q;
      ex_mem_mem_wr_d     = ex_mem_mem_wr_q;
      if (!stall_i) begin
         ex_mem_alu_d        = alu_res;
         ex_mem_store_d      = rs2_fwd;
         ex_mem_pc4_d        = PC_I + XLEN'(4);
         ex_mem_rd_d         = id_ex_rd;
         ex_mem_funct3_d     = Funct3_I;
         ex_mem_src_to_reg_d = Src_to_Reg_I;
         // Wrong-path instructions flow through but cannot change architectural state.
         ex_mem_reg_wr_d     = Reg_Wr_En_I & live;
         ex_mem_mem_wr_d     = MEM_Wr_En_I & live;
      end
   end

   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         ex_mem_alu_q        <= '0;
         ex_mem_store_q      <= '0;
         ex_mem_pc4_q        <= '0;
         ex_mem_rd_q         <= '0;
         ex_mem_funct3_q     <= '0;
         ex_mem_src_to_reg_q <= '0;
         ex_mem_reg_wr_q     <= 1'b0;
         ex_mem_mem_wr_q     <= 1'b0;
         squash_cnt_q        <= '0;
      end else begin
         ex_mem_alu_q        <= ex_mem_alu_d;
         ex_mem_store_q      <= ex_mem_store_d;
         ex_mem_pc4_q        <= ex_mem_pc4_d;
         ex_mem_rd_q         <= ex_mem_rd_d;
         ex_mem_funct3_q     <= ex_mem_funct3_d;
         ex_mem_src_to_reg_q <= ex_mem_src_to_reg_d;
         ex_mem_reg_wr_q     <= ex_mem_reg_wr_d;
         ex_mem_mem_wr_q     <= ex_mem_mem_wr_d;
         squash_cnt_q        <= squash_cnt_d;
      end
   end

   assign ex_mem_alu_o        = ex_mem_alu_q;
   assign ex_mem_store_o      = ex_mem_store_q;
   assign ex_mem_pc4_o        = ex_mem_pc4_q;
   assign ex_mem_rd_o         = ex_mem_rd_q;
   assign ex_mem_funct3_o     = ex_mem_funct3_q;
   assign ex_mem_src_to_reg_o = ex_mem_src_to_reg_q;
   assign ex_mem_reg_wr_o     = ex_mem_reg_wr_q;
   assign ex_mem_mem_wr_o     = ex_mem_mem_wr_q;

endmodule
